// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin sequencer sharing one 32-bit ripple-carry adder between two requesters
module adder_arbiter #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_sum,
    output logic        rsp_carryout,
    output logic        rsp_overflow,
    output logic        busy
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        prio_q, prio_d;
    logic        id_q, id_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_id_q, rsp_id_d;
    logic [31:0] rsp_sum_q, rsp_sum_d;
    logic        rsp_carryout_q, rsp_carryout_d;
    logic        rsp_overflow_q, rsp_overflow_d;

    logic        any_valid;
    logic        gnt_id;
    logic [32:0] carry;
    logic [31:0] sum_w;
    logic        ovf_w;

    // A lone requester wins; on contention the round-robin pointer decides.
    assign any_valid  = req0_valid | req1_valid;
    assign gnt_id     = (req0_valid && req1_valid) ? prio_q : req1_valid;
    assign req0_ready = (state_q == ST_IDLE) && any_valid && !gnt_id;
    assign req1_ready = (state_q == ST_IDLE) && any_valid && gnt_id;

    always_comb begin
        carry    = '0;
        sum_w    = '0;
        carry[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sum_w[i]     = op_a_q[i] ^ op_b_q[i] ^ carry[i];
            carry[i + 1] = (op_a_q[i] & op_b_q[i]) | (carry[i] & (op_a_q[i] ^ op_b_q[i]));
        end
        ovf_w = (op_a_q[31] == op_b_q[31]) && (sum_w[31] != op_a_q[31]);
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        prio_d         = prio_q;
        id_d           = id_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_sum_d      = rsp_sum_q;
        rsp_carryout_d = rsp_carryout_q;
        rsp_overflow_d = rsp_overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    id_d    = gnt_id;
                    prio_d  = ~gnt_id;
                    op_a_d  = gnt_id ? req1_a : req0_a;
                    op_b_d  = gnt_id ? req1_b : req0_b;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    rsp_sum_d      = sum_w;
                    rsp_carryout_d = carry[32];
                    rsp_overflow_d = ovf_w;
                    rsp_id_d       = id_q;
                    rsp_valid_d    = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            prio_q         <= 1'b0;
            id_q           <= 1'b0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= 1'b0;
            rsp_sum_q      <= '0;
            rsp_carryout_q <= 1'b0;
            rsp_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            prio_q         <= prio_d;
            id_q           <= id_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_sum_q      <= rsp_sum_d;
            rsp_carryout_q <= rsp_carryout_d;
            rsp_overflow_q <= rsp_overflow_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_sum      = rsp_sum_q;
    assign rsp_carryout = rsp_carryout_q;
    assign rsp_overflow = rsp_overflow_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed-vector bench for adder_arbiter at SETTLE_CYCLES 2 and 3
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carryout, rsp_overflow, busy;
    logic [31:0] rsp_sum;

    logic        d3_req0_valid = 1'b0, d3_rsp_ready = 1'b0;
    logic [31:0] d3_req0_a = '0, d3_req0_b = '0;
    logic        d3_req0_ready, d3_req1_ready, d3_rsp_valid, d3_rsp_id;
    logic        d3_rsp_carryout, d3_rsp_overflow, d3_busy;
    logic [31:0] d3_rsp_sum;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.SETTLE_CYCLES(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow), .busy(busy)
    );

    adder_arbiter #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(d3_req0_valid), .req0_ready(d3_req0_ready), .req0_a(d3_req0_a), .req0_b(d3_req0_b),
        .req1_valid(1'b0), .req1_ready(d3_req1_ready), .req1_a(32'h0), .req1_b(32'h0),
        .rsp_valid(d3_rsp_valid), .rsp_ready(d3_rsp_ready), .rsp_id(d3_rsp_id), .rsp_sum(d3_rsp_sum),
        .rsp_carryout(d3_rsp_carryout), .rsp_overflow(d3_rsp_overflow), .busy(d3_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, " req0_ready"}, {31'd0, req0_ready}, 32'd0);
        check_eq({tag, " req1_ready"}, {31'd0, req1_ready}, 32'd0);
        check_eq({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check_eq({tag, " rsp_id"}, {31'd0, rsp_id}, 32'd0);
        check_eq({tag, " rsp_sum"}, rsp_sum, 32'd0);
        check_eq({tag, " rsp_carryout"}, {31'd0, rsp_carryout}, 32'd0);
        check_eq({tag, " rsp_overflow"}, {31'd0, rsp_overflow}, 32'd0);
        check_eq({tag, " busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_rsp(input string tag, input logic id, input logic [31:0] sum,
                             input logic co, input logic ov);
        check_eq({tag, " rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
        check_eq({tag, " rsp_id"}, {31'd0, rsp_id}, {31'd0, id});
        check_eq({tag, " rsp_sum"}, rsp_sum, sum);
        check_eq({tag, " rsp_carryout"}, {31'd0, rsp_carryout}, {31'd0, co});
        check_eq({tag, " rsp_overflow"}, {31'd0, rsp_overflow}, {31'd0, ov});
    endtask

    initial begin
        #2;
        check_idle_outputs("reset");
        step();
        rst_n = 1'b1;
        step();

        // Contended grant, then reset while the op is settling.
        req0_valid = 1'b1; req0_a = 32'h0000_0005; req0_b = 32'h0000_0006;
        req1_valid = 1'b1; req1_a = 32'h0000_0007; req1_b = 32'h0000_0008;
        #1;
        check_eq("first grant req0_ready", {31'd0, req0_ready}, 32'd1);
        check_eq("first grant req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check_eq("settle busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid-settle reset");
        step();
        step();
        check_eq("no rsp under reset", {31'd0, rsp_valid}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single op; prio must be back at 0 so req0 wins the tie.
        req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_b = 32'hFFFF_FFFF;
        req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'h0000_0002;
        #1;
        check_eq("post-reset req0_ready", {31'd0, req0_ready}, 32'd1);
        check_eq("post-reset req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'hDEAD_BEEF; req0_b = 32'h1234_5678;
        #1;
        check_eq("settle1 rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("settle1 req0_ready", {31'd0, req0_ready}, 32'd0);
        step();
        check_eq("settle2 rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        check_rsp("single", 1'b0, 32'h0000_0000, 1'b1, 1'b0);

        // Backpressure with both requesters pending.
        req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'hFFFF_FFFB;
        req1_valid = 1'b1; req1_a = 32'h7FFF_FFFF; req1_b = 32'h0000_0002;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_rsp("bp hold", 1'b0, 32'h0000_0000, 1'b1, 1'b0);
            check_eq("bp busy", {31'd0, busy}, 32'd1);
            check_eq("bp req0_ready", {31'd0, req0_ready}, 32'd0);
            check_eq("bp req1_ready", {31'd0, req1_ready}, 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        check_eq("post-hs rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("post-hs busy", {31'd0, busy}, 32'd0);
        check_eq("post-hs rsp_sum held", rsp_sum, 32'h0000_0000);
        check_eq("post-hs rsp_carryout held", {31'd0, rsp_carryout}, 32'd1);

        // Fairness: both valid continuously, grants alternate 1,0,1.
        check_eq("fair1 req1_ready", {31'd0, req1_ready}, 32'd1);
        check_eq("fair1 req0_ready", {31'd0, req0_ready}, 32'd0);
        step();
        step();
        step();
        check_rsp("fair1 rsp", 1'b1, 32'h8000_0001, 1'b0, 1'b1);
        step();
        check_eq("fair2 req0_ready", {31'd0, req0_ready}, 32'd1);
        check_eq("fair2 req1_ready", {31'd0, req1_ready}, 32'd0);
        step();
        step();
        step();
        check_rsp("neg ovf rsp", 1'b0, 32'h7FFF_FFFB, 1'b1, 1'b1);
        step();
        check_eq("fair3 req1_ready", {31'd0, req1_ready}, 32'd1);
        check_eq("fair3 req0_ready", {31'd0, req0_ready}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        // Throughput at SETTLE_CYCLES=3: accepts every 5 cycles.
        d3_rsp_ready = 1'b1;
        d3_req0_valid = 1'b1; d3_req0_a = 32'hFFFB_FFFF; d3_req0_b = 32'h0000_0001;
        #1;
        for (int i = 0; i < 12; i++) begin
            check_eq($sformatf("tp%0d req0_ready", i), {31'd0, d3_req0_ready},
                     {31'd0, (i % 5) == 0});
            check_eq($sformatf("tp%0d rsp_valid", i), {31'd0, d3_rsp_valid},
                     {31'd0, (i % 5) == 4});
            if (i == 4) begin
                check_eq("tp rsp_sum", d3_rsp_sum, 32'hFFFC_0000);
                check_eq("tp rsp_carryout", {31'd0, d3_rsp_carryout}, 32'd0);
                check_eq("tp rsp_overflow", {31'd0, d3_rsp_overflow}, 32'd0);
                check_eq("tp rsp_id", {31'd0, d3_rsp_id}, 32'd0);
            end
            step();
        end
        d3_req0_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
